// File: rtl/pspin_egress_cmd_sched_if.sv
// Command/response bundle between the PsPIN command sources, the scheduler and the egress DMA.
// The slave view is the scheduler; the master view is whatever drives sources and DMA.
`timescale 1ns/1ps
interface pspin_egress_cmd_sched_if #(
   parameter int NUM_SRC             = 2,
   parameter int CMD_ID_WIDTH        = 6,
   parameter int AXI_HOST_ADDR_WIDTH = 64,
   parameter int LEN_WIDTH           = 32,
   parameter int SRC_W               = $clog2(NUM_SRC)
);
   logic [NUM_SRC-1:0]                     s_cmd_valid;
   logic [NUM_SRC-1:0]                     s_cmd_ready;
   logic [NUM_SRC*CMD_ID_WIDTH-1:0]        s_cmd_id;
   logic [NUM_SRC*AXI_HOST_ADDR_WIDTH-1:0] s_cmd_src_addr;
   logic [NUM_SRC*LEN_WIDTH-1:0]           s_cmd_length;
   logic [NUM_SRC-1:0]                     s_resp_valid;
   logic [NUM_SRC*CMD_ID_WIDTH-1:0]        s_resp_id;
   logic                                   m_cmd_valid;
   logic                                   m_cmd_ready;
   logic [SRC_W+CMD_ID_WIDTH-1:0]          m_cmd_tag;
   logic [AXI_HOST_ADDR_WIDTH-1:0]         m_cmd_src_addr;
   logic [LEN_WIDTH-1:0]                   m_cmd_length;
   logic                                   m_resp_valid;
   logic [SRC_W+CMD_ID_WIDTH-1:0]          m_resp_tag;
   logic [3:0]                             m_resp_error;

   modport slave (
      input  s_cmd_valid, s_cmd_id, s_cmd_src_addr, s_cmd_length,
             m_cmd_ready, m_resp_valid, m_resp_tag, m_resp_error,
      output s_cmd_ready, s_resp_valid, s_resp_id,
             m_cmd_valid, m_cmd_tag, m_cmd_src_addr, m_cmd_length
   );

   modport master (
      output s_cmd_valid, s_cmd_id, s_cmd_src_addr, s_cmd_length,
             m_cmd_ready, m_resp_valid, m_resp_tag, m_resp_error,
      input  s_cmd_ready, s_resp_valid, s_resp_id,
             m_cmd_valid, m_cmd_tag, m_cmd_src_addr, m_cmd_length
   );
endinterface

// File: rtl/pspin_egress_cmd_sched.sv
// Round-robin scheduler of per-cluster NIC commands onto one egress DMA command port,
// with in-flight cap, completion routing back to sources and error/occupancy status.
//
// state    | meaning
// ST_IDLE  | output slot empty, may grant one source per cycle
// ST_ISSUE | output slot holds a command waiting for m_cmd_ready
`timescale 1ns/1ps
module pspin_egress_cmd_sched #(
   parameter int NUM_SRC             = 2,
   parameter int CMD_ID_WIDTH        = 6,
   parameter int AXI_HOST_ADDR_WIDTH = 64,
   parameter int LEN_WIDTH           = 32,
   parameter int MAX_INFLIGHT        = 8
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                enable,
   pspin_egress_cmd_sched_if.slave             cmd_if,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_count,
   output logic [15:0]                         err_count,
   output logic [3:0]                          last_error,
   output logic [$clog2(NUM_SRC)-1:0]          last_error_src,
   output logic                                spurious
);
   localparam int SRC_W = $clog2(NUM_SRC);
   localparam int CNT_W = $clog2(MAX_INFLIGHT+1);

   typedef enum logic [0:0] {ST_IDLE, ST_ISSUE} state_t;

   state_t                          r_state;
   logic [SRC_W-1:0]                r_rr;
   logic [CNT_W-1:0]                r_inflight;
   logic                            r_m_valid;
   logic [SRC_W+CMD_ID_WIDTH-1:0]   r_m_tag;
   logic [AXI_HOST_ADDR_WIDTH-1:0]  r_m_addr;
   logic [LEN_WIDTH-1:0]            r_m_len;
   logic                            r_zl_pend;
   logic [SRC_W-1:0]                r_zl_src;
   logic [CMD_ID_WIDTH-1:0]         r_zl_id;
   logic [NUM_SRC-1:0]              r_resp_valid;
   logic [NUM_SRC*CMD_ID_WIDTH-1:0] r_resp_id;
   logic [15:0]                     r_err_count;
   logic [3:0]                      r_last_error;
   logic [SRC_W-1:0]                r_last_error_src;
   logic                            r_spurious;

   logic                            w_can_grant;
   logic                            w_gnt_any;
   logic [SRC_W-1:0]                w_gnt_idx;
   logic                            w_grant;
   logic [CMD_ID_WIDTH-1:0]         w_sel_id;
   logic [AXI_HOST_ADDR_WIDTH-1:0]  w_sel_addr;
   logic [LEN_WIDTH-1:0]            w_sel_len;
   logic [SRC_W-1:0]                w_rsp_src;
   logic [CMD_ID_WIDTH-1:0]         w_rsp_id;
   logic                            w_rsp_ok;
   logic                            w_inc;
   logic                            w_zl_fire;

   // Only IDLE grants, so the output slot is empty whenever a grant is possible.
   assign w_can_grant = rstn && (r_state == ST_IDLE) && enable && !r_zl_pend
                        && (r_inflight < CNT_W'(MAX_INFLIGHT));

   always_comb begin
      int               idx;
      logic [SRC_W-1:0] idx_s;
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      idx       = 0;
      idx_s     = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = int'(r_rr) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         idx_s = SRC_W'(idx);
         if (!w_gnt_any && cmd_if.s_cmd_valid[idx_s]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = idx_s;
         end
      end
   end

   assign w_grant    = w_can_grant && w_gnt_any;
   assign w_sel_id   = cmd_if.s_cmd_id[w_gnt_idx*CMD_ID_WIDTH +: CMD_ID_WIDTH];
   assign w_sel_addr = cmd_if.s_cmd_src_addr[w_gnt_idx*AXI_HOST_ADDR_WIDTH +: AXI_HOST_ADDR_WIDTH];
   assign w_sel_len  = cmd_if.s_cmd_length[w_gnt_idx*LEN_WIDTH +: LEN_WIDTH];

   assign w_rsp_src  = cmd_if.m_resp_tag[CMD_ID_WIDTH +: SRC_W];
   assign w_rsp_id   = cmd_if.m_resp_tag[CMD_ID_WIDTH-1:0];
   assign w_rsp_ok   = cmd_if.m_resp_valid && (int'(w_rsp_src) < NUM_SRC) && (r_inflight != '0);
   assign w_inc      = r_m_valid && cmd_if.m_cmd_ready;
   // A zero-length completion yields to a DMA status aimed at the same source this cycle.
   assign w_zl_fire  = r_zl_pend && !(cmd_if.m_resp_valid && (w_rsp_src == r_zl_src));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state          <= ST_IDLE;
         r_rr             <= '0;
         r_inflight       <= '0;
         r_m_valid        <= 1'b0;
         r_m_tag          <= '0;
         r_m_addr         <= '0;
         r_m_len          <= '0;
         r_zl_pend        <= 1'b0;
         r_zl_src         <= '0;
         r_zl_id          <= '0;
         r_resp_valid     <= '0;
         r_resp_id        <= '0;
         r_err_count      <= '0;
         r_last_error     <= '0;
         r_last_error_src <= '0;
         r_spurious       <= 1'b0;
      end else begin
         r_resp_valid <= '0;
         if (w_rsp_ok) begin
            r_resp_valid[w_rsp_src] <= 1'b1;
            r_resp_id[w_rsp_src*CMD_ID_WIDTH +: CMD_ID_WIDTH] <= w_rsp_id;
            if (cmd_if.m_resp_error != 4'h0) begin
               if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
               r_last_error     <= cmd_if.m_resp_error;
               r_last_error_src <= w_rsp_src;
            end
         end else if (cmd_if.m_resp_valid) begin
            r_spurious <= 1'b1;
         end

         if (w_zl_fire) begin
            r_resp_valid[r_zl_src] <= 1'b1;
            r_resp_id[r_zl_src*CMD_ID_WIDTH +: CMD_ID_WIDTH] <= r_zl_id;
            r_zl_pend <= 1'b0;
         end

         if (w_inc && !w_rsp_ok)      r_inflight <= r_inflight + 1'b1;
         else if (!w_inc && w_rsp_ok) r_inflight <= r_inflight - 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_rr <= (w_gnt_idx == SRC_W'(NUM_SRC-1)) ? '0 : w_gnt_idx + 1'b1;
                  if (w_sel_len != '0) begin
                     r_m_valid <= 1'b1;
                     r_m_tag   <= {w_gnt_idx, w_sel_id};
                     r_m_addr  <= w_sel_addr;
                     r_m_len   <= w_sel_len;
                     r_state   <= ST_ISSUE;
                  end else begin
                     r_zl_pend <= 1'b1;
                     r_zl_src  <= w_gnt_idx;
                     r_zl_id   <= w_sel_id;
                  end
               end
            end
            ST_ISSUE: begin
               if (cmd_if.m_cmd_ready) begin
                  r_m_valid <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      cmd_if.s_cmd_ready = '0;
      if (w_grant) cmd_if.s_cmd_ready[w_gnt_idx] = 1'b1;
   end

   assign cmd_if.s_resp_valid   = r_resp_valid;
   assign cmd_if.s_resp_id      = r_resp_id;
   assign cmd_if.m_cmd_valid    = r_m_valid;
   assign cmd_if.m_cmd_tag      = r_m_tag;
   assign cmd_if.m_cmd_src_addr = r_m_addr;
   assign cmd_if.m_cmd_length   = r_m_len;
   assign inflight_count        = r_inflight;
   assign err_count             = r_err_count;
   assign last_error            = r_last_error;
   assign last_error_src        = r_last_error_src;
   assign spurious              = r_spurious;
endmodule

// File: tb/tb_pspin_egress_cmd_sched.sv
// Bench for pspin_egress_cmd_sched: table vectors, directed corner sequences, then
// random traffic checked against a transaction-level model of sources and DMA.
`timescale 1ns/1ps
module tb_pspin_egress_cmd_sched;
   localparam int NS = 2, IW = 6, AW = 64, LW = 32, MAXI = 8, SW = 1, CW = 4, TW = SW + IW;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic enable = 1'b0;
   logic [CW-1:0] inflight_count;
   logic [15:0]   err_count;
   logic [3:0]    last_error;
   logic [SW-1:0] last_error_src;
   logic          spurious;
   int n_chk = 0, n_pass = 0;

   pspin_egress_cmd_sched_if #(.NUM_SRC(NS), .CMD_ID_WIDTH(IW), .AXI_HOST_ADDR_WIDTH(AW),
                               .LEN_WIDTH(LW)) bus ();

   pspin_egress_cmd_sched #(.NUM_SRC(NS), .CMD_ID_WIDTH(IW), .AXI_HOST_ADDR_WIDTH(AW),
                            .LEN_WIDTH(LW), .MAX_INFLIGHT(MAXI)) dut (
      .clk(clk), .rstn(rstn), .enable(enable), .cmd_if(bus),
      .inflight_count(inflight_count), .err_count(err_count), .last_error(last_error),
      .last_error_src(last_error_src), .spurious(spurious)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            src;
      logic [IW-1:0] id;
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
      logic [3:0]    err;
      logic [TW-1:0] e_tag;
      logic [15:0]   e_ec;
      logic [3:0]    e_le;
      logic          e_ls;
   } vec_t;
   vec_t tbl[5];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.s_cmd_valid    = '0;
      bus.s_cmd_id       = '0;
      bus.s_cmd_src_addr = '0;
      bus.s_cmd_length   = '0;
      bus.m_cmd_ready    = 1'b0;
      bus.m_resp_valid   = 1'b0;
      bus.m_resp_tag     = '0;
      bus.m_resp_error   = '0;
   endtask

   task automatic set_cmd(input int s, input logic [IW-1:0] id, input logic [AW-1:0] a,
                          input logic [LW-1:0] l);
      bus.s_cmd_valid[s]            = 1'b1;
      bus.s_cmd_id[s*IW +: IW]      = id;
      bus.s_cmd_src_addr[s*AW +: AW] = a;
      bus.s_cmd_length[s*LW +: LW]  = l;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle_in();
      repeat (2) tick();
      rstn = 1'b1;
      tick();
   endtask

   function automatic logic [IW-1:0] rid(input int s);
      return bus.s_resp_id[s*IW +: IW];
   endfunction

   // random-phase reference model state
   logic [TW-1:0]    outq[$];
   int               m_inf, m_rr, m_zls, g, pick, rsrc, ng;
   logic             m_busy, m_zlp, m_ls, m_sp;
   logic [IW-1:0]    m_zli;
   logic [TW-1:0]    m_tag;
   logic [AW-1:0]    m_addr;
   logic [LW-1:0]    m_len;
   logic [NS-1:0]    m_rv, exp_rdy, oh;
   logic [NS*IW-1:0] m_rid;
   logic [15:0]      m_ec;
   logic [3:0]       m_le;

   initial begin
      tbl[0] = '{0, 6'd5,  64'h1000,                32'd64,        4'h0, 7'h05, 16'd0, 4'h0, 1'b0};
      tbl[1] = '{1, 6'd3,  64'h2000,                32'd16,        4'h2, 7'h43, 16'd1, 4'h2, 1'b1};
      tbl[2] = '{1, 6'd9,  64'h2040,                32'd8,         4'h0, 7'h49, 16'd1, 4'h2, 1'b1};
      tbl[3] = '{0, 6'd63, 64'hFFFF_FFFF_0000_0000, 32'd1,         4'hF, 7'h3F, 16'd2, 4'hF, 1'b0};
      tbl[4] = '{1, 6'd0,  64'h0,                   32'hFFFF_FFFF, 4'h0, 7'h40, 16'd2, 4'hF, 1'b0};

      // reset state, with requests present
      idle_in();
      enable = 1'b1;
      bus.s_cmd_valid = '1;
      #3;
      check("rst_ready", bus.s_cmd_ready, 0);
      check("rst_mvalid", bus.m_cmd_valid, 0);
      check("rst_rvalid", bus.s_resp_valid, 0);
      check("rst_inflight", inflight_count, 0);
      check("rst_errcnt", err_count, 0);
      check("rst_lasterr", last_error, 0);
      check("rst_spurious", spurious, 0);
      do_reset();

      // table: one command per vector, issue, complete, verify status
      for (int i = 0; i < 5; i++) begin
         enable = 1'b1;
         set_cmd(tbl[i].src, tbl[i].id, tbl[i].addr, tbl[i].len);
         oh = '0;
         oh[tbl[i].src] = 1'b1;
         #1;
         check("tbl_ready", bus.s_cmd_ready, oh);
         tick();
         bus.s_cmd_valid = '0;
         check("tbl_mvalid", bus.m_cmd_valid, 1);
         check("tbl_tag", bus.m_cmd_tag, tbl[i].e_tag);
         check("tbl_addr", bus.m_cmd_src_addr, tbl[i].addr);
         check("tbl_len", bus.m_cmd_length, tbl[i].len);
         bus.m_cmd_ready = 1'b1;
         tick();
         bus.m_cmd_ready = 1'b0;
         check("tbl_mvalid_off", bus.m_cmd_valid, 0);
         check("tbl_inflight1", inflight_count, 1);
         bus.m_resp_valid = 1'b1;
         bus.m_resp_tag   = tbl[i].e_tag;
         bus.m_resp_error = tbl[i].err;
         tick();
         bus.m_resp_valid = 1'b0;
         check("tbl_rvalid", bus.s_resp_valid, oh);
         check("tbl_rid", rid(tbl[i].src), tbl[i].id);
         check("tbl_inflight0", inflight_count, 0);
         check("tbl_errcnt", err_count, tbl[i].e_ec);
         check("tbl_lasterr", last_error, tbl[i].e_le);
         check("tbl_lastsrc", last_error_src, tbl[i].e_ls);
         tick();
         check("tbl_rpulse", bus.s_resp_valid, 0);
      end

      // response with nothing outstanding
      bus.m_resp_valid = 1'b1;
      bus.m_resp_tag   = 7'h47;
      bus.m_resp_error = 4'h3;
      tick();
      bus.m_resp_valid = 1'b0;
      check("spur_flag", spurious, 1);
      check("spur_rvalid", bus.s_resp_valid, 0);
      check("spur_errcnt", err_count, 2);

      // backpressure hold, then async reset mid-hold
      enable = 1'b1;
      bus.m_cmd_ready = 1'b0;
      set_cmd(0, 6'd10, 64'hABCD, 32'd100);
      set_cmd(1, 6'd11, 64'h1234, 32'd50);
      tick();
      for (int c = 0; c < 10; c++) begin
         check("bp_mvalid", bus.m_cmd_valid, 1);
         check("bp_tag", bus.m_cmd_tag, 7'h0A);
         check("bp_addr", bus.m_cmd_src_addr, 64'hABCD);
         check("bp_len", bus.m_cmd_length, 100);
         #1;
         check("bp_noready", bus.s_cmd_ready, 0);
         tick();
      end
      rstn = 1'b0;
      #1;
      check("rstmid_mvalid", bus.m_cmd_valid, 0);
      check("rstmid_inflight", inflight_count, 0);
      check("rstmid_errcnt", err_count, 0);
      check("rstmid_spurious", spurious, 0);
      idle_in();
      tick();
      rstn = 1'b1;
      tick();
      bus.m_resp_valid = 1'b1;
      bus.m_resp_tag   = 7'h0A;
      tick();
      bus.m_resp_valid = 1'b0;
      check("post_rst_spurious", spurious, 1);
      check("post_rst_rvalid", bus.s_resp_valid, 0);

      // cap and round-robin order with no completions
      do_reset();
      enable = 1'b1;
      bus.m_cmd_ready = 1'b1;
      set_cmd(0, 6'd1, 64'h100, 32'd4);
      set_cmd(1, 6'd2, 64'h200, 32'd4);
      ng = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (bus.s_cmd_ready != '0) begin
            oh = (ng % 2 == 0) ? 2'b01 : 2'b10;
            check("fair_order", bus.s_cmd_ready, oh);
            ng++;
         end
         tick();
      end
      check("cap_grants", ng, 8);
      check("cap_inflight", inflight_count, 8);
      #1;
      check("cap_noready", bus.s_cmd_ready, 0);
      bus.m_resp_valid = 1'b1;
      bus.m_resp_tag   = 7'h01;
      tick();
      bus.m_resp_valid = 1'b0;
      check("cap_dec", inflight_count, 7);
      ng = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (bus.s_cmd_ready != '0) ng++;
         tick();
      end
      check("cap_one_more", ng, 1);
      check("cap_refill", inflight_count, 8);

      // zero-length command colliding with a DMA status for the same source
      do_reset();
      enable = 1'b1;
      set_cmd(1, 6'd2, 64'h3000, 32'd8);
      tick();
      bus.s_cmd_valid = '0;
      bus.m_cmd_ready = 1'b1;
      tick();
      bus.m_cmd_ready = 1'b0;
      check("zl_inflight1", inflight_count, 1);
      set_cmd(1, 6'd3, 64'h4000, 32'd0);
      bus.m_resp_valid = 1'b1;
      bus.m_resp_tag   = 7'h42;
      #1;
      check("zl_ready", bus.s_cmd_ready, 2'b10);
      tick();
      idle_in();
      check("zl_dma_first", bus.s_resp_valid, 2'b10);
      check("zl_dma_id", rid(1), 2);
      check("zl_no_mvalid", bus.m_cmd_valid, 0);
      tick();
      check("zl_second", bus.s_resp_valid, 2'b10);
      check("zl_id", rid(1), 3);
      check("zl_no_mvalid2", bus.m_cmd_valid, 0);
      check("zl_inflight0", inflight_count, 0);
      tick();
      check("zl_pulse_end", bus.s_resp_valid, 0);

      // random traffic against the model
      do_reset();
      outq.delete();
      m_inf = 0; m_rr = 0; m_busy = 0; m_zlp = 0; m_zls = 0; m_zli = '0;
      m_tag = '0; m_addr = '0; m_len = '0;
      m_rv = '0; m_rid = '0; m_ec = '0; m_le = '0; m_ls = 0; m_sp = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         check("rnd_rvalid", bus.s_resp_valid, m_rv);
         check("rnd_rid", bus.s_resp_id, m_rid);
         check("rnd_inflight", inflight_count, m_inf);
         check("rnd_errcnt", err_count, m_ec);
         check("rnd_lasterr", last_error, m_le);
         check("rnd_lastsrc", last_error_src, m_ls);
         check("rnd_spurious", spurious, m_sp);
         check("rnd_mvalid", bus.m_cmd_valid, m_busy);
         if (m_busy) begin
            check("rnd_tag", bus.m_cmd_tag, m_tag);
            check("rnd_addr", bus.m_cmd_src_addr, m_addr);
            check("rnd_len", bus.m_cmd_length, m_len);
         end

         enable = ($urandom_range(9) != 0);
         for (int s = 0; s < NS; s++) begin
            bus.s_cmd_valid[s]             = 1'($urandom_range(1));
            bus.s_cmd_id[s*IW +: IW]       = IW'($urandom);
            bus.s_cmd_src_addr[s*AW +: AW] = {$urandom, $urandom};
            bus.s_cmd_length[s*LW +: LW]   = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom_range(1000, 1));
         end
         bus.m_cmd_ready  = ($urandom_range(2) != 0);
         bus.m_resp_valid = 1'b0;
         pick = -1;
         if (outq.size() > 0 && $urandom_range(2) == 0) begin
            pick = $urandom_range(outq.size() - 1);
            bus.m_resp_valid = 1'b1;
            bus.m_resp_tag   = outq[pick];
         end else if (outq.size() == 0 && $urandom_range(19) == 0) begin
            bus.m_resp_valid = 1'b1;
            bus.m_resp_tag   = TW'($urandom);
         end
         bus.m_resp_error = ($urandom_range(3) == 0) ? 4'($urandom_range(15, 1)) : 4'h0;
         #1;

         g = -1;
         if (enable && !m_busy && !m_zlp && m_inf < MAXI)
            for (int k = 0; k < NS; k++)
               if (g < 0 && bus.s_cmd_valid[(m_rr + k) % NS]) g = (m_rr + k) % NS;
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         check("rnd_grant", bus.s_cmd_ready, exp_rdy);

         m_rv = '0;
         rsrc = int'(bus.m_resp_tag[TW-1 -: SW]);
         if (bus.m_resp_valid) begin
            if (m_inf > 0) begin
               m_rv[rsrc] = 1'b1;
               m_rid[rsrc*IW +: IW] = bus.m_resp_tag[IW-1:0];
               m_inf--;
               if (pick >= 0) outq.delete(pick);
               if (bus.m_resp_error != 4'h0) begin
                  if (m_ec != 16'hFFFF) m_ec++;
                  m_le = bus.m_resp_error;
                  m_ls = SW'(rsrc);
               end
            end else begin
               m_sp = 1'b1;
            end
         end
         if (m_zlp && !(bus.m_resp_valid && rsrc == m_zls)) begin
            m_rv[m_zls] = 1'b1;
            m_rid[m_zls*IW +: IW] = m_zli;
            m_zlp = 1'b0;
         end
         if (m_busy && bus.m_cmd_ready) begin
            outq.push_back(m_tag);
            m_inf++;
            m_busy = 1'b0;
         end
         if (g >= 0) begin
            m_rr = (g + 1) % NS;
            if (bus.s_cmd_length[g*LW +: LW] != '0) begin
               m_busy = 1'b1;
               m_tag  = {SW'(g), bus.s_cmd_id[g*IW +: IW]};
               m_addr = bus.s_cmd_src_addr[g*AW +: AW];
               m_len  = bus.s_cmd_length[g*LW +: LW];
            end else begin
               m_zlp = 1'b1;
               m_zls = g;
               m_zli = bus.s_cmd_id[g*IW +: IW];
            end
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pspin_egress_cmd_sched.md
Name: pspin_egress_cmd_sched

Overview:
Arbitrates NIC commands from NUM_SRC PsPIN command sources (one per cluster) onto the single egress DMA command port. Tags each forwarded command with its source index and enforces a cap on outstanding DMA commands. Routes DMA completion status back to the originating source and keeps error and occupancy status for the control registers. Sits between the PsPIN NIC-command outputs and the egress DMA descriptor/status interface.

Parameters:
NUM_SRC, 2, number of command sources (≥2)
SRC_W, $clog2(NUM_SRC), source index width (derived)
CMD_ID_WIDTH, 6, per-source command id width
AXI_HOST_ADDR_WIDTH, 64, command source-address width
LEN_WIDTH, 32, command length width
MAX_INFLIGHT, 8, max outstanding forwarded commands (≥1)
CNT_W, $clog2(MAX_INFLIGHT+1), in-flight counter width (derived)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
enable  in  1  when low, no new grants (in-progress output command still completes)
s_cmd_valid  in  NUM_SRC  per-source command valid
s_cmd_ready  out  NUM_SRC  per-source command accept
s_cmd_id  in  NUM_SRC*CMD_ID_WIDTH  packed per-source ids (source i at bits [i*CMD_ID_WIDTH +: CMD_ID_WIDTH])
s_cmd_src_addr  in  NUM_SRC*AXI_HOST_ADDR_WIDTH  packed source addresses
s_cmd_length  in  NUM_SRC*LEN_WIDTH  packed lengths
s_resp_valid  out  NUM_SRC  per-source completion pulse
s_resp_id  out  NUM_SRC*CMD_ID_WIDTH  packed completed ids
m_cmd_valid  out  1  command to DMA
m_cmd_ready  in  1  DMA accept
m_cmd_tag  out  SRC_W+CMD_ID_WIDTH  {src_idx, id}
m_cmd_src_addr  out  AXI_HOST_ADDR_WIDTH  forwarded address
m_cmd_length  out  LEN_WIDTH  forwarded length
m_resp_valid  in  1  DMA status valid (single-cycle, no backpressure)
m_resp_tag  in  SRC_W+CMD_ID_WIDTH  status tag
m_resp_error  in  4  DMA status error code
inflight_count  out  CNT_W  outstanding forwarded commands
err_count  out  16  completions with nonzero error, saturating
last_error  out  4  error code of most recent nonzero-error completion
last_error_src  out  SRC_W  source of that completion
spurious  out  1  sticky: response with no outstanding command or bad source index

Behaviour:
- Reset (async, rstn=0): all outputs 0; rr pointer=0; FSM=IDLE; zero-length pending flag clear.
- FSM IDLE: grant allowed iff enable && inflight_count+(pending output)<MAX_INFLIGHT && !zl_pending. Round-robin from rr pointer over asserted s_cmd_valid. s_cmd_ready[g] asserted combinationally in the grant cycle only, one-hot at most. On grant, rr pointer <= g+1 (wraps at NUM_SRC).
- Grant with length!=0: register {g,id}, addr, length into output stage -> ISSUE. m_cmd_valid is high from the next cycle (1-cycle latency); payload stable until m_cmd_ready.
- ISSUE: on m_cmd_valid&&m_cmd_ready, inflight_count++ and return to IDLE. No grants while in ISSUE (single output slot).
- Grant with length==0: not forwarded. Set zl_pending with {g,id}. Emit s_resp_valid[g] with that id in the first cycle where m_resp_valid is low, or where m_resp_valid is high but routes to a different source. Then clear zl_pending. Does not touch inflight_count or error status.
- Response path: on m_resp_valid, src=m_resp_tag[top SRC_W bits]. If src<NUM_SRC and inflight_count>0: s_resp_valid[src]=1 and s_resp_id[src]=low bits, registered (1-cycle latency, single-cycle pulse), and inflight_count--. Otherwise drop and set spurious.
- inflight_count: simultaneous increment and decrement leaves it unchanged. It never exceeds MAX_INFLIGHT and never underflows.
- Error status: nonzero m_resp_error on an accepted response does err_count++ (saturates at 0xFFFF), last_error<=error, last_error_src<=src. Zero error leaves these unchanged.
- s_resp_id of non-pulsing sources holds its last value.
- Reset mid-operation: everything clears. DMA statuses arriving afterwards with inflight_count==0 set spurious.

Test Plan:
- Single command: src0 id=5, addr=0x1000, len=64 -> m_cmd_valid next cycle, tag={0,5}. DMA returns tag {0,5}, err 0 -> s_resp_valid[0] one cycle later with id 5; inflight 1→0.
- Fairness: both sources valid continuously, m_cmd_ready=1, responses immediate -> grants alternate 0,1,0,1; no source waits more than NUM_SRC grants.
- Cap: MAX_INFLIGHT=8, no responses -> exactly 8 forwarded, s_cmd_ready stays 0. One response -> exactly one more grant; inflight back to 8.
- Zero-length: src1 id=3 len=0 while a DMA response for src1 arrives in the same cycle -> DMA response delivered first, zl response for id 3 delivered next cycle; m_cmd_valid never asserted for it.
- Errors: response err=4'h2 for src1, then err 0 -> err_count=1, last_error=2, last_error_src=1. Response with inflight 0 -> spurious=1, no s_resp_valid.
- Backpressure/reset: m_cmd_ready=0 for 10 cycles -> payload stable, no further grants. Assert rstn=0 mid-hold -> m_cmd_valid=0 immediately, counters 0.
